// File: rtl/lu_bit_sequencer.sv
// Bit-serial sequencer around a 1-bit OR/NOR/XOR/XNOR logic unit: feeds operands LSB-first and
// reassembles the result word. Define LU_SEQ_BACK2BACK_EN to accept a new command during DONE.
module lu_bit_sequencer #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WIDTH-1:0] cmd_a_i,
    input  logic [WIDTH-1:0] cmd_b_i,
    input  logic [1:0]       cmd_op_i,
    output logic             lu_a_o,
    output logic             lu_b_o,
    output logic [1:0]       lu_sel_o,
    input  logic             lu_s_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, rsp_data_q;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] idx_q;
    logic [WIDTH-1:0] res_upd;
    logic             load;

    // Result word including the bit arriving from the unit this cycle.
    always_comb begin
        res_upd         = res_q;
        res_upd[idx_q]  = lu_s_i;
    end

    always_comb begin
`ifdef LU_SEQ_BACK2BACK_EN
        cmd_ready_o = (state_q == StIdle) || ((state_q == StDone) && rsp_ready_i);
`else
        cmd_ready_o = (state_q == StIdle);
`endif
    end

    assign load        = cmd_valid_i && cmd_ready_o;
    assign lu_a_o      = (state_q == StRun) ? a_q[idx_q] : 1'b0;
    assign lu_b_o      = (state_q == StRun) ? b_q[idx_q] : 1'b0;
    assign lu_sel_o    = (state_q == StRun) ? op_q : 2'b00;
    assign rsp_valid_o = (state_q == StDone);
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = (state_q != StIdle);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 2'b00;
            res_q      <= '0;
            rsp_data_q <= '0;
            idx_q      <= '0;
        end else if (load) begin
            // In DONE this also completes the outstanding response handshake.
            state_q <= StRun;
            a_q     <= cmd_a_i;
            b_q     <= cmd_b_i;
            op_q    <= cmd_op_i;
            res_q   <= '0;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StRun: begin
                    res_q <= res_upd;
                    if (idx_q == LastIdx) begin
                        state_q    <= StDone;
                        rsp_data_q <= res_upd;
                    end else begin
                        idx_q <= idx_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    if (rsp_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lu_bit_sequencer.sv
// Directed bench for lu_bit_sequencer with a behavioural 1-bit logic unit in the loop.
module tb_lu_bit_sequencer;

    logic       clk, rst_n;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_a, cmd_b;
    logic [1:0] cmd_op;
    logic       lu_a, lu_b, lu_s;
    logic [1:0] lu_sel;
    logic       rsp_valid, rsp_ready, busy;
    logic [7:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    lu_bit_sequencer #(.WIDTH(8)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_a_i    (cmd_a),
        .cmd_b_i    (cmd_b),
        .cmd_op_i   (cmd_op),
        .lu_a_o     (lu_a),
        .lu_b_o     (lu_b),
        .lu_sel_o   (lu_sel),
        .lu_s_i     (lu_s),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o (rsp_data),
        .busy_o     (busy)
    );

    // The 1-bit logic unit: 00=OR, 01=NOR, 10=XOR, 11=XNOR.
    always_comb begin
        case (lu_sel)
            2'b00:   lu_s = lu_a | lu_b;
            2'b01:   lu_s = ~(lu_a | lu_b);
            2'b10:   lu_s = lu_a ^ lu_b;
            default: lu_s = ~(lu_a ^ lu_b);
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the sequencer idle; returns at the negedge where rsp_valid is seen.
    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                            input int pulse_at, output logic [7:0] lu_a_seq, output int lat);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        check_eq("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat       = 0;
        lu_a_seq  = '0;
        while (!rsp_valid && lat < 20) begin
            if (lat < 8) lu_a_seq[lat] = lu_a;
            if (lat == pulse_at) begin
                cmd_valid = 1'b1;
                cmd_a     = ~a;
                cmd_b     = ~b;
                cmd_op    = ~op;
            end
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
            lat++;
        end
        check_eq("rsp_latency", lat, 32'd8);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    logic [7:0] seq;
    logic [7:0] held;
    int         lat;
    int         k;
    logic [7:0] exp_or_table [4] = '{8'hAF, 8'h50, 8'hAA, 8'h55};

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = 2'b00;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        check_eq("rst_lu", {28'd0, lu_a, lu_b, lu_sel}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All four opcodes on A5/0F.
        for (int op = 0; op < 4; op++) begin
            send_cmd(8'hA5, 8'h0F, 2'(op), -1, seq, lat);
            check_eq($sformatf("op%0d_data", op), {24'd0, rsp_data}, {24'd0, exp_or_table[op]});
            finish_rsp();
        end

        // LSB-first serialization.
        send_cmd(8'h01, 8'h00, 2'b00, -1, seq, lat);
        check_eq("serial_lu_a", {24'd0, seq}, 32'h01);
        check_eq("serial_data", {24'd0, rsp_data}, 32'h01);
        check_eq("done_lu_zero", {28'd0, lu_a, lu_b, lu_sel}, 32'd0);

        // Backpressure for 5 cycles in DONE.
        held = rsp_data;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("bp_rsp_data", {24'd0, rsp_data}, {24'd0, held});
            check_eq("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        finish_rsp();
        check_eq("idle_data_hold", {24'd0, rsp_data}, {24'd0, held});

        // cmd_valid pulsed mid-RUN with other data must be ignored.
        send_cmd(8'h3C, 8'hC3, 2'b10, 3, seq, lat);
        check_eq("ignore_pulse_data", {24'd0, rsp_data}, 32'hFF);
        finish_rsp();

        // Asynchronous reset at idx=3.
        cmd_valid = 1'b1;
        cmd_a     = 8'hFF;
        cmd_b     = 8'hFF;
        cmd_op    = 2'b00;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("pre_rst_lu_a", {31'd0, lu_a}, 32'd1);
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("async_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("async_rst_lu", {28'd0, lu_a, lu_b, lu_sel}, 32'd0);
        check_eq("async_rst_rsp", {23'd0, rsp_valid, rsp_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        send_cmd(8'hFF, 8'hFF, 2'b10, -1, seq, lat);
        check_eq("post_rst_data", {24'd0, rsp_data}, 32'h00);
        finish_rsp();

        // Back-to-back commands with an always-ready consumer.
        cmd_valid = 1'b1;
        cmd_a     = 8'hA5;
        cmd_b     = 8'h0F;
        cmd_op    = 2'b10;
        rsp_ready = 1'b1;
        k = 0;
        while (!rsp_valid && k < 30) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check_eq("b2b_first_rsp", {31'd0, rsp_valid}, 32'd1);
        check_eq("b2b_first_data", {24'd0, rsp_data}, 32'hAA);
`ifdef LU_SEQ_BACK2BACK_EN
        check_eq("b2b_done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
`else
        check_eq("b2b_done_cmd_ready", {31'd0, cmd_ready}, 32'd0);
`endif
        k = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end while (!rsp_valid && k < 30);
        cmd_valid = 1'b0;
`ifdef LU_SEQ_BACK2BACK_EN
        check_eq("b2b_spacing", k, 32'd9);
`else
        check_eq("b2b_spacing", k, 32'd10);
`endif
        check_eq("b2b_second_data", {24'd0, rsp_data}, 32'hAA);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("b2b_end_busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
